interval_arbiter: RTL and testbench

Controller that shares one WIDTH-bit tick counter between two requesters, each asking for a timed interval of a programmable number of clock cycles. Round-robin arbitration picks a requester, the block runs the counter for that requester's interval, then signals completion. It sits in front of the counter datapath as its sole sequencer; requesters never drive the counter directly.

---
 rtl/interval_arbiter.sv | 121 ++++++++++++
 tb/tb_interval_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/interval_arbiter.sv
// Round-robin sequencer that shares one tick counter between two requesters,
// running the counter for the granted requester's interval and pulsing done.
//
// Handshake: requester i raises req[i] and holds it until done[i] or abort;
// dropping req[i] while granted aborts the interval with no done pulse.
module interval_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;

  logic             pick;
  logic [WIDTH-1:0] last;

  // Length 0 wraps to all-ones, giving a full 2^WIDTH-cycle interval.
  assign last = len_q - WIDTH'(1);

  // Both pending: the priority holder wins; otherwise the single requester.
  assign pick = (req == 2'b11) ? prio_q : req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        cnt_d = '0;
        if (req != 2'b00) begin
          state_d = RUN;
          owner_d = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          len_d   = pick ? len1 : len0;
          prio_d  = ~pick;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end else if (cnt_q == last) begin
          state_d = DONE;
          gnt_d   = 2'b00;
          done_d  = owner_q ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cnt       = cnt_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// Directed bench for interval_arbiter: a vector table for reset, single and
// contended intervals, plus hand sequences for full length, abort, mid-run reset.
module tb_interval_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             clr;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic [1:0]       fsm_state;

  int checks = 0;
  int errors = 0;

  interval_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt       (cnt),
    .fsm_state (fsm_state)
  );

  // Active edge is the falling edge; the bench drives and samples on the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             clr;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic [1:0] r, input logic [WIDTH-1:0] l0,
                     input logic [WIDTH-1:0] l1, input logic [1:0] g, input logic [1:0] d,
                     input logic b, input logic [WIDTH-1:0] n);
    vec_t v;
    v.clr = c; v.req = r; v.len0 = l0; v.len1 = l1;
    v.gnt = g; v.done = d; v.busy = b; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(input string name, input logic [1:0] g, input logic [1:0] d,
                       input logic b, input logic [WIDTH-1:0] n);
    checks += 4;
    if (gnt !== g) begin
      errors++;
      $display("FAIL %s gnt: got %b expected %b", name, gnt, g);
    end
    if (done !== d) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, d);
    end
    if (busy !== b) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", name, busy, b);
    end
    if (cnt !== n) begin
      errors++;
      $display("FAIL %s cnt: got %0d expected %0d", name, cnt, n);
    end
  endtask

  initial begin
    clr = 1'b1; req = 2'b11; len0 = '0; len1 = '0;
    repeat (2) @(posedge clk);
    check("reset_hold", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    check("reset_hold_edge", 2'b00, 2'b00, 1'b0, 4'd0);
    clr = 1'b0; req = 2'b00;
    step();
    check("idle_after_reset", 2'b00, 2'b00, 1'b0, 4'd0);

    //   clr  req    len0  len1  gnt    done   busy cnt
    add(0, 2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1, 4'd0);
    add(0, 2'b01, 4'd9, 4'd0, 2'b01, 2'b00, 1, 4'd1);
    add(0, 2'b01, 4'd9, 4'd0, 2'b01, 2'b00, 1, 4'd2);
    add(0, 2'b01, 4'd9, 4'd0, 2'b00, 2'b01, 1, 4'd0);
    add(0, 2'b00, 4'd9, 4'd0, 2'b00, 2'b00, 0, 4'd0);
    // Priority now points at 1; reset must restore it to 0.
    add(1, 2'b11, 4'd2, 4'd4, 2'b00, 2'b00, 0, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b01, 2'b00, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b01, 2'b00, 1, 4'd1);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b01, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b00, 0, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b10, 2'b00, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b10, 2'b00, 1, 4'd1);
    add(0, 2'b11, 4'd2, 4'd4, 2'b10, 2'b00, 1, 4'd2);
    add(0, 2'b11, 4'd2, 4'd4, 2'b10, 2'b00, 1, 4'd3);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b10, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b00, 0, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b01, 2'b00, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b01, 2'b00, 1, 4'd1);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b01, 1, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b00, 2'b00, 0, 4'd0);
    add(0, 2'b11, 4'd2, 4'd4, 2'b10, 2'b00, 1, 4'd0);
    // Dropping req1 mid-interval aborts straight to IDLE.
    add(0, 2'b00, 4'd2, 4'd4, 2'b00, 2'b00, 0, 4'd0);

    foreach (vecs[i]) begin
      clr = vecs[i].clr; req = vecs[i].req; len0 = vecs[i].len0; len1 = vecs[i].len1;
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt);
    end

    // Full-length interval: len1 = 0 runs 16 cycles.
    req = 2'b10; len1 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("full_run%0d", i), 2'b10, 2'b00, 1'b1, WIDTH'(i));
    end
    step();
    check("full_done", 2'b00, 2'b10, 1'b1, 4'd0);
    req = 2'b00;
    step();
    check("full_idle", 2'b00, 2'b00, 1'b0, 4'd0);

    // Abort: requester 0 with len0 = 8 drops req after cnt = 3; req1 pending.
    req = 2'b11; len0 = 4'd8; len1 = 4'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort_run%0d", i), 2'b01, 2'b00, 1'b1, WIDTH'(i));
    end
    req = 2'b10;
    step();
    check("abort_idle", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    check("abort_next_grant", 2'b10, 2'b00, 1'b1, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("r1_run%0d", i), 2'b10, 2'b00, 1'b1, WIDTH'(i));
    end

    // Mid-run reset at cnt = 5 must clear outputs without waiting for an edge.
    #2 clr = 1'b1;
    #1 check("midrun_clr_async", 2'b00, 2'b00, 1'b0, 4'd0);
    step();
    check("midrun_clr_held", 2'b00, 2'b00, 1'b0, 4'd0);
    clr = 1'b0; req = 2'b11; len0 = 4'd2;
    step();
    check("post_clr_prio0", 2'b01, 2'b00, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
